// File: rtl/hazard_pkg.sv
// Shared types and helpers for the decode-stage issue scoreboard.
// Build option: SCOREBOARD_FWD_EN selects forwarding-on latencies.
package hazard_pkg;

  typedef enum logic [1:0] {
    OP_ALU   = 2'd0,
    OP_LOAD  = 2'd1,
    OP_MULT  = 2'd2,
    OP_OTHER = 2'd3
  } op_class_t;

  typedef logic [3:0] count_t;

  // Extra latency when results only become visible after writeback.
  localparam int FWD_OFF_ADD = 2;

  function automatic logic [5:0] entry_idx(input logic fp, input logic [4:0] r);
    return {fp, r};
  endfunction

endpackage

// File: rtl/sb_counter.sv
// Loadable 4-bit down-counter that saturates at zero; busy while non-zero.
module sb_counter
  import hazard_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   load,
  input  count_t load_val,
  output count_t count,
  output logic   busy
);

  // A load wins over the decrement so a re-issue on the final cycle restarts the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 4'd1;
    end
  end

  assign busy = (count != '0);

endmodule

// File: rtl/issue_scoreboard.sv
// Decode-stage issue scoreboard: 64 register countdowns plus the shared multiplier sequencer.
// Build option: define SCOREBOARD_FWD_EN when EX/MEM forwarding is present.
module issue_scoreboard
  import hazard_pkg::*;
#(
  parameter int LOAD_LAT = 2,
  parameter int MULT_LAT = 10,
  parameter int ALU_LAT  = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       issue_valid,
  input  logic [4:0] src_a,
  input  logic [4:0] src_b,
  input  logic       src_a_use,
  input  logic       src_b_use,
  input  logic       src_a_fp,
  input  logic       src_b_fp,
  input  logic [4:0] dst,
  input  logic       dst_we,
  input  logic       dst_fp,
  input  logic [1:0] op_class,
  output logic       stall,
  output logic       mult_start,
  output logic       mult_busy,
  output logic       mult_done,
  output logic [4:0] mult_dst,
  output logic       mult_dst_fp
);

`ifdef SCOREBOARD_FWD_EN
  localparam int LAT_ADD = 0;
`else
  localparam int LAT_ADD = FWD_OFF_ADD;
`endif

  localparam count_t ALU_EFF  = count_t'(ALU_LAT + LAT_ADD);
  localparam count_t LOAD_EFF = count_t'(LOAD_LAT + LAT_ADD);
  localparam count_t MULT_EFF = count_t'(MULT_LAT + LAT_ADD);
  localparam count_t MULT_CNT = count_t'(MULT_LAT);

  op_class_t  cls;
  count_t     lat;
  logic [5:0] a_idx, b_idx, d_idx;
  logic       d_is_r0;
  count_t     cnt [64];
  logic [63:0] busy;
  logic       src_hit, waw_hit, mult_hit;
  logic       issue, entry_load, mult_load;
  count_t     mult_cnt;

  assign cls     = op_class_t'(op_class);
  assign a_idx   = entry_idx(src_a_fp, src_a);
  assign b_idx   = entry_idx(src_b_fp, src_b);
  assign d_idx   = entry_idx(dst_fp, dst);
  assign d_is_r0 = !dst_fp && (dst == 5'd0);

  always_comb begin
    lat = '0;
    case (cls)
      OP_ALU:   lat = ALU_EFF;
      OP_LOAD:  lat = LOAD_EFF;
      OP_MULT:  lat = MULT_EFF;
      default:  lat = '0;
    endcase
  end

  // Integer r0 is never loaded, so its entry can never report busy or trip WAW.
  assign src_hit  = (src_a_use && busy[a_idx]) || (src_b_use && busy[b_idx]);
  assign waw_hit  = dst_we && (cnt[d_idx] > lat);
  assign mult_hit = (cls == OP_MULT) && mult_busy;
  assign stall    = issue_valid && (src_hit || waw_hit || mult_hit);

  assign issue      = issue_valid && !stall;
  assign entry_load = issue && dst_we && (lat != '0) && !d_is_r0;
  assign mult_load  = issue && (cls == OP_MULT);

  for (genvar g = 0; g < 64; g++) begin : g_entry
    sb_counter u_entry (
      .clk      (clk),
      .rst      (rst),
      .load     (entry_load && (d_idx == 6'(g))),
      .load_val (lat),
      .count    (cnt[g]),
      .busy     (busy[g])
    );
  end

  sb_counter u_mult (
    .clk      (clk),
    .rst      (rst),
    .load     (mult_load),
    .load_val (MULT_CNT),
    .count    (mult_cnt),
    .busy     (mult_busy)
  );

  // A new mult cannot load while the counter is busy, so count==1 always means a 1->0 step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mult_start  <= 1'b0;
      mult_done   <= 1'b0;
      mult_dst    <= '0;
      mult_dst_fp <= 1'b0;
    end else begin
      mult_start <= mult_load;
      mult_done  <= (mult_cnt == 4'd1);
      if (mult_load) begin
        mult_dst    <= dst;
        mult_dst_fp <= dst_fp;
      end
    end
  end

endmodule

// File: tb/tb_issue_scoreboard.sv
// Randomized and directed bench for issue_scoreboard against a ready-time reference model.
// Honours SCOREBOARD_FWD_EN the same way the design does.
module tb_issue_scoreboard;

  localparam int LOAD_LAT = 2;
  localparam int MULT_LAT = 10;
  localparam int ALU_LAT  = 0;
`ifdef SCOREBOARD_FWD_EN
  localparam int ADD = 0;
`else
  localparam int ADD = 2;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       issue_valid;
  logic [4:0] src_a, src_b, dst;
  logic       src_a_use, src_b_use, src_a_fp, src_b_fp;
  logic       dst_we, dst_fp;
  logic [1:0] op_class;
  logic       stall, mult_start, mult_busy, mult_done, mult_dst_fp;
  logic [4:0] mult_dst;

  int checks   = 0;
  int failures = 0;

  // Model: absolute edge number at which each register's result becomes ready.
  int         e = 0;
  int         ready [64];
  bit         m_valid;
  int         m_ready;
  logic [4:0] m_dst;
  logic       m_fp;
  logic       exp_start;

  always #5 clk = ~clk;

  issue_scoreboard #(
    .LOAD_LAT (LOAD_LAT),
    .MULT_LAT (MULT_LAT),
    .ALU_LAT  (ALU_LAT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .issue_valid (issue_valid),
    .src_a       (src_a),
    .src_b       (src_b),
    .src_a_use   (src_a_use),
    .src_b_use   (src_b_use),
    .src_a_fp    (src_a_fp),
    .src_b_fp    (src_b_fp),
    .dst         (dst),
    .dst_we      (dst_we),
    .dst_fp      (dst_fp),
    .op_class    (op_class),
    .stall       (stall),
    .mult_start  (mult_start),
    .mult_busy   (mult_busy),
    .mult_done   (mult_done),
    .mult_dst    (mult_dst),
    .mult_dst_fp (mult_dst_fp)
  );

  function automatic int eff_lat(input logic [1:0] cls);
    case (cls)
      2'd0:    return ALU_LAT + ADD;
      2'd1:    return LOAD_LAT + ADD;
      2'd2:    return MULT_LAT + ADD;
      default: return 0;
    endcase
  endfunction

  function automatic int cnt_of(input int idx);
    return (ready[idx] > e) ? ready[idx] - e : 0;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s observed=%0d expected=%0d (edge %0d)", tag, obs, exp, e);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < 64; i++) ready[i] = e;
    m_valid   = 1'b0;
    m_ready   = 0;
    m_dst     = '0;
    m_fp      = 1'b0;
    exp_start = 1'b0;
  endtask

  task automatic applyStimulus(input logic v, input logic [4:0] a, input logic au, input logic af,
                               input logic [4:0] b, input logic bu, input logic bf,
                               input logic [4:0] d, input logic we, input logic df,
                               input logic [1:0] cls, output logic issued);
    int   lat, ai, bi, di;
    logic exp_stall;
    @(negedge clk);
    issue_valid = v;  src_a = a; src_a_use = au; src_a_fp = af;
    src_b = b; src_b_use = bu; src_b_fp = bf;
    dst = d; dst_we = we; dst_fp = df; op_class = cls;
    #1;
    lat = eff_lat(cls);
    ai  = int'({af, a});
    bi  = int'({bf, b});
    di  = int'({df, d});
    exp_stall = v && ((au && ai != 0 && cnt_of(ai) > 0) ||
                      (bu && bi != 0 && cnt_of(bi) > 0) ||
                      (we && cnt_of(di) > lat) ||
                      (cls == 2'd2 && m_valid && e < m_ready));
    checkOutput("stall",       32'(stall),       32'(exp_stall));
    checkOutput("mult_busy",   32'(mult_busy),   32'(m_valid && e < m_ready));
    checkOutput("mult_done",   32'(mult_done),   32'(m_valid && e == m_ready));
    checkOutput("mult_start",  32'(mult_start),  32'(exp_start));
    checkOutput("mult_dst",    32'(mult_dst),    32'(m_dst));
    checkOutput("mult_dst_fp", 32'(mult_dst_fp), 32'(m_fp));
    issued = v && !exp_stall;
    @(posedge clk);
    #1;
    e++;
    exp_start = issued && (cls == 2'd2);
    if (issued && we && lat > 0 && di != 0) ready[di] = e + lat;
    if (exp_start) begin
      m_valid = 1'b1;
      m_ready = e + MULT_LAT;
      m_dst   = d;
      m_fp    = df;
    end
  endtask

  task automatic idle(input int n);
    logic iss;
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, iss);
  endtask

  // Present the same instruction until it issues; returns how many cycles it stalled.
  task automatic issueUntil(input logic [4:0] a, input logic au, input logic af,
                            input logic [4:0] d, input logic we, input logic df,
                            input logic [1:0] cls, output int stalls);
    logic iss;
    stalls = 0;
    iss    = 1'b0;
    for (int i = 0; i < 60 && !iss; i++) begin
      applyStimulus(1, a, au, af, 0, 0, 0, d, we, df, cls, iss);
      if (!iss) stalls++;
    end
    if (!iss) checkOutput("issue_timeout", 0, 1);
  endtask

  task automatic doReset();
    @(posedge clk);
    #3;
    rst = 1'b1;
    issue_valid = 1'b0;
    #1;
    checkOutput("rst_mult_busy",   32'(mult_busy),   0);
    checkOutput("rst_mult_done",   32'(mult_done),   0);
    checkOutput("rst_mult_start",  32'(mult_start),  0);
    checkOutput("rst_mult_dst",    32'(mult_dst),    0);
    checkOutput("rst_mult_dst_fp", 32'(mult_dst_fp), 0);
    checkOutput("rst_stall",       32'(stall),       0);
    @(negedge clk);
    rst = 1'b0;
    modelReset();
  endtask

  initial begin
    int   s, total;
    logic iss;
    rst = 1'b1;
    issue_valid = 0; src_a = 0; src_b = 0; src_a_use = 0; src_b_use = 0;
    src_a_fp = 0; src_b_fp = 0; dst = 0; dst_we = 0; dst_fp = 0; op_class = 0;
    modelReset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    idle(2);

    // Load r3 then an ALU op reading r3.
    issueUntil(3, 0, 0, 3, 1, 0, 2'd1, s);
    issueUntil(3, 1, 0, 8, 1, 0, 2'd0, s);
    checkOutput("load_use_stalls", 32'(s), 32'(eff_lat(2'd1)));
    idle(20);

    // Back-to-back multiplies: the second waits for the first to finish.
    issueUntil(0, 0, 0, 4, 1, 1, 2'd2, s);
    issueUntil(0, 0, 0, 5, 1, 1, 2'd2, s);
    checkOutput("mult_mult_stalls", 32'(s), 32'(MULT_LAT));
    idle(20);

    // r0 is never a hazard.
    issueUntil(0, 0, 0, 0, 1, 0, 2'd1, s);
    issueUntil(0, 1, 0, 9, 1, 0, 2'd0, s);
    checkOutput("r0_stalls", 32'(s), 0);
    idle(20);

    // WAW: ALU write to r7 behind a multiply writing r7.
    issueUntil(0, 0, 0, 7, 1, 0, 2'd2, s);
    issueUntil(0, 0, 0, 7, 1, 0, 2'd0, s);
    checkOutput("waw_stalls", 32'(s), 32'(eff_lat(2'd2) - eff_lat(2'd0)));
    idle(20);

    // ALU write r5 then read r5.
    issueUntil(0, 0, 0, 5, 1, 0, 2'd0, s);
    issueUntil(5, 1, 0, 10, 1, 0, 2'd0, s);
    checkOutput("alu_use_stalls", 32'(s), 32'(eff_lat(2'd0)));
    idle(20);

    // Independent stream over r1..r6.
    total = 0;
    for (int i = 0; i < 3; i++) begin
      issueUntil(5'(i + 4), 1, 0, 5'(i + 1), 1, 0, 2'd0, s);
      total += s;
    end
    checkOutput("indep_stalls", 32'(total), 0);
    idle(20);

    // Reset with a multiply in flight, then a fresh multiply right away.
    issueUntil(0, 0, 0, 9, 1, 0, 2'd2, s);
    idle(4);
    doReset();
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 11, 1, 1, 2'd2, iss);
    checkOutput("post_rst_mult_issued", 32'(iss), 1);
    idle(15);

    // Random traffic over a small register window to provoke hazards.
    for (int n = 0; n < 3000; n++) begin
      applyStimulus($urandom_range(0, 9) != 0,
                    5'($urandom_range(0, 7)), 1'($urandom), 1'($urandom),
                    5'($urandom_range(0, 7)), 1'($urandom), 1'($urandom),
                    5'($urandom_range(0, 7)), 1'($urandom), 1'($urandom),
                    2'($urandom_range(0, 3)), iss);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
